// File: rtl/uart_bus_bridge.sv
// UART-to-MMIO debug bridge: 'W' a3 a2 a1 a0 d -> write, reply 'K'; 'R' a3 a2 a1 a0 -> read, reply data.
// Define UART_BUS_BRIDGE_TIMEOUT_EN to abandon a half-received command after TIMEOUT_CLKS idle clocks.
module uart_bus_bridge #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int BUS_CYCLES   = 2,
  parameter int TIMEOUT_CLKS = 5_000_000
) (
  input  logic        CLOCK_50MHz,
  input  logic        RESET,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        AS_L,
  output logic        WE_L,
  output logic [31:0] Address,
  output logic [7:0]  DataOut,
  input  logic [7:0]  DataIn,
  output logic        busy
);
  localparam int DIV  = CLK_HZ / BAUD - 1;
  localparam int CW   = $clog2(DIV + 2);
  localparam int HALF = (DIV + 1) / 2 - 1;
  localparam logic [3:0] BUS_LAST = 4'(BUS_CYCLES - 1);
  localparam logic [7:0] CMD_W = 8'h57, CMD_R = 8'h52, RSP_OK = 8'h4B, RSP_BAD = 8'h3F;

  typedef enum logic [2:0] {P_CMD, P_ADDR, P_DATA, P_BUS, P_REPLY} pstate_t;

  pstate_t        state, state_nx;
  logic           rx_meta, rx_sync, rx_prev, rx_busy, rx_strobe, rx_ferr;
  logic [CW-1:0]  rx_cnt, tx_cnt;
  logic [3:0]     rx_phase, tx_left;
  logic [7:0]     rx_shift, reply;
  logic [8:0]     tx_shift;
  logic           tx_busy, tx_start, tx_done;
  logic           op_wr, parsing, cmd_ok, abort, timeout_hit;
  logic [1:0]     idx;
  logic [31:0]    addr_sr, addr_nx;
  logic [3:0]     bus_cnt;

  // RX: phase 0 re-checks the start bit, 1..8 shift data LSB first, 9 checks the stop bit.
  always_ff @(posedge CLOCK_50MHz) begin
    if (RESET) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      rx_busy   <= 1'b0;
      rx_cnt    <= '0;
      rx_phase  <= '0;
      rx_shift  <= '0;
      rx_strobe <= 1'b0;
      rx_ferr   <= 1'b0;
    end else begin
      // NOTE: every flop in a clocked block uses <= so all of them see pre-edge values of each other.
      rx_meta   <= uart_rx;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      rx_strobe <= 1'b0;
      rx_ferr   <= 1'b0;
      if (!rx_busy) begin
        if (rx_prev && !rx_sync) begin
          rx_busy  <= 1'b1;
          rx_phase <= '0;
          rx_cnt   <= CW'(HALF);
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt   <= CW'(DIV);
        rx_phase <= rx_phase + 1'b1;
        if (rx_phase == 4'd0) begin
          if (rx_sync) rx_busy <= 1'b0;
        end else if (rx_phase <= 4'd8) begin
          rx_shift <= {rx_sync, rx_shift[7:1]};
        end else begin
          rx_busy   <= 1'b0;
          rx_strobe <= rx_sync;
          rx_ferr   <= !rx_sync;
        end
      end
    end
  end

  // TX: start bit goes out on launch, then nine more bits (data LSB first, stop) from tx_shift.
  always_ff @(posedge CLOCK_50MHz) begin
    if (RESET) begin
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_shift <= '0;
      tx_cnt   <= '0;
      tx_left  <= '0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_busy) begin
        if (tx_start) begin
          uart_tx  <= 1'b0;
          tx_shift <= {1'b1, reply};
          tx_cnt   <= CW'(DIV);
          tx_left  <= 4'd9;
          tx_busy  <= 1'b1;
        end
      end else if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - 1'b1;
      end else if (tx_left == '0) begin
        tx_busy <= 1'b0;
        tx_done <= 1'b1;
      end else begin
        uart_tx  <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[8:1]};
        tx_left  <= tx_left - 1'b1;
        tx_cnt   <= CW'(DIV);
      end
    end
  end

  assign parsing = (state == P_CMD) || (state == P_ADDR) || (state == P_DATA);
  assign cmd_ok  = (rx_shift == CMD_W) || (rx_shift == CMD_R);
  assign addr_nx = {addr_sr[23:0], rx_shift};
  // Line errors only matter while a command is being parsed; during BUS/REPLY the byte is ignored anyway.
  assign abort   = parsing && (rx_ferr || timeout_hit);

`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
  logic [31:0] to_cnt;

  always_ff @(posedge CLOCK_50MHz) begin
    if (RESET || rx_strobe || !((state == P_ADDR) || (state == P_DATA))) to_cnt <= '0;
    else                                                                  to_cnt <= to_cnt + 32'd1;
  end

  assign timeout_hit = ((state == P_ADDR) || (state == P_DATA)) && !rx_strobe &&
                       (to_cnt >= 32'(TIMEOUT_CLKS - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CLKS > 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge CLOCK_50MHz) begin
    if (RESET) state <= P_CMD;
    else       state <= state_nx;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    case (state)
      P_CMD:   if (rx_strobe) state_nx = cmd_ok ? P_ADDR : P_REPLY;
      P_ADDR:  if (rx_strobe && idx == 2'd3) state_nx = op_wr ? P_DATA : P_BUS;
      P_DATA:  if (rx_strobe) state_nx = P_BUS;
      P_BUS:   if (bus_cnt == '0) state_nx = P_REPLY;
      P_REPLY: if (tx_done) state_nx = P_CMD;
      default: state_nx = P_CMD;
    endcase
    if (abort) state_nx = P_CMD;
  end

  // Bus outputs change only when a cycle launches, so Address/DataOut hold between accesses.
  always_ff @(posedge CLOCK_50MHz) begin
    if (RESET) begin
      AS_L     <= 1'b1;
      WE_L     <= 1'b1;
      Address  <= '0;
      DataOut  <= '0;
      busy     <= 1'b0;
      op_wr    <= 1'b0;
      idx      <= '0;
      addr_sr  <= '0;
      reply    <= '0;
      bus_cnt  <= '0;
      tx_start <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        P_CMD: if (rx_strobe) begin
          busy  <= 1'b1;
          op_wr <= (rx_shift == CMD_W);
          idx   <= '0;
          if (!cmd_ok) begin
            reply    <= RSP_BAD;
            tx_start <= 1'b1;
          end
        end
        P_ADDR: if (rx_strobe) begin
          addr_sr <= addr_nx;
          idx     <= idx + 1'b1;
          if (idx == 2'd3 && !op_wr) begin
            Address <= addr_nx;
            WE_L    <= 1'b1;
            AS_L    <= 1'b0;
            bus_cnt <= BUS_LAST;
          end
        end
        P_DATA: if (rx_strobe) begin
          DataOut <= rx_shift;
          Address <= addr_sr;
          WE_L    <= 1'b0;
          AS_L    <= 1'b0;
          bus_cnt <= BUS_LAST;
        end
        P_BUS: begin
          if (bus_cnt == '0) begin
            AS_L     <= 1'b1;
            reply    <= op_wr ? RSP_OK : DataIn;
            tx_start <= 1'b1;
          end else begin
            bus_cnt <= bus_cnt - 1'b1;
          end
        end
        P_REPLY: begin
          WE_L <= 1'b1;
          if (tx_done) busy <= 1'b0;
        end
        default: ;
      endcase
      if (abort) busy <= 1'b0;
    end
  end
endmodule
